seq_divider32x16: RTL and testbench
===================================

Name: seq_divider32x16

Overview:
- Iterative unsigned divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, producing quotient and remainder.
- Inverse of the combinational 16x16 multiplier path. The dividend is taken as {dividend_hi, dividend_lo}, the same hi/lo pairing as the MUL result (aluout2/aluout1), so a product feeds back directly.
- Sits beside the ALU in execute. The control unit stalls on busy and writes quotient/remainder to two registers on done.

Parameters:
WIDTH  16  operand/result width; dividend is 2*WIDTH bits; iteration count = WIDTH

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; accepted only when busy=0
abort  input  1  pipeline flush; cancels an in-flight divide
dividend_hi  input  WIDTH  upper half of dividend
dividend_lo  input  WIDTH  lower half of dividend
divisor  input  WIDTH  divisor
quotient  output  WIDTH  registered quotient
remainder  output  WIDTH  registered remainder
busy  output  1  high while in RUN
done  output  1  one-cycle completion pulse
div_by_zero  output  1  last accepted op had divisor==0
overflow  output  1  last accepted op had quotient wider than WIDTH (dividend_hi >= divisor, divisor != 0)
zero_q  output  1  last completed quotient == 0

Behaviour:
- Reset: synchronous, active-high, one clock, sampled on rising clk. State=IDLE. quotient, remainder, busy, done, div_by_zero, overflow and zero_q are all 0. Reset overrides start and abort in every state, including mid-RUN.
- States:
  - IDLE: accept start.
  - RUN: iterate.
  - DONE: one cycle; done=1; accepts start exactly as IDLE does.
- Accept: start=1, busy=0, reset=0 at edge N.
  - Operands are latched; the inputs may change afterwards.
  - div_by_zero, overflow and zero_q are cleared, then re-evaluated as below.
- Error path, decided at the accept edge:
  - divisor==0: next state DONE, div_by_zero=1, quotient={WIDTH{1}}, remainder=0.
  - Else if dividend_hi >= divisor: next state DONE, overflow=1, quotient={WIDTH{1}}, remainder=0.
  - div_by_zero has priority over overflow.
  - done is visible in the cycle after edge N (latency 1). busy is never asserted.
- Normal path:
  - Next state RUN, busy=1. Working regs: R (WIDTH+1 bits) = {0, dividend_hi}; Q = dividend_lo; count = 0.
  - Each RUN edge, restoring step:
    - {R,Q} shifted left 1; T = R - divisor (WIDTH+1 bit).
    - If T is non-negative: R=T and Q[0]=1; else Q[0]=0.
    - count increments.
  - After the WIDTH-th step (edge N+WIDTH):
    - State=DONE, busy=0, done=1.
    - quotient=Q, remainder=R[WIDTH-1:0], zero_q=(Q==0).
  - Latency = WIDTH cycles (16) from accept edge to done visible.
- Output registers (quotient, remainder, flags) change only at completion or at accept (flag clear). They hold their values through RUN and until the next accepted start.
- DONE leaves after one cycle:
  - To RUN or DONE if start is accepted that edge (back-to-back allowed; done is high for one cycle per op).
  - Otherwise to IDLE.
- start while busy=1: ignored, no queuing.
- abort:
  - In RUN: next state IDLE, busy=0, no done pulse; outputs keep their previous completed values, with flags as cleared at accept.
  - In IDLE/DONE: no effect; a start in the same cycle is still accepted.
  - abort and an in-RUN final step on the same edge: abort wins, no done.
- Invariant: remainder < divisor whenever done=1 and neither error flag is set.
- All outputs are registered; no combinational input-to-output path.

Test Plan:
1. Reset held 2 cycles while start=1 with valid operands -> all outputs 0, busy=0, no done. Assert reset during RUN at step 5 -> next cycle all outputs 0, state IDLE, no done pulse.
2. hi=0x0000, lo=0x0064, divisor=0x0007, start 1 cycle -> busy for 16 cycles; done at accept+16; quotient=0x000E, remainder=0x0002, zero_q=0, flags 0.
3. hi=0xFFFE, lo=0x0001, divisor=0xFFFF -> quotient=0xFFFF, remainder=0x0000. Then immediately, with start held in the DONE cycle, hi=0, lo=0x0003, divisor=0x0010 -> second done 16 cycles later, quotient=0x0000, remainder=0x0003, zero_q=1.
4. divisor=0x0000 (hi=0x0005) -> done 1 cycle after accept, busy never 1, div_by_zero=1, overflow=0, quotient=0xFFFF, remainder=0. Then hi=0x0010, divisor=0x0010 -> overflow=1, div_by_zero=0, same 1-cycle latency.
5. Start 0x0001_0000 / 0x0010, pulse abort at RUN step 5 -> busy drops next cycle, no done; quotient/remainder unchanged from the prior op. Then restart the same op -> quotient=0x1000, remainder=0x0000.
6. Start asserted continuously during a RUN with different operands -> ignored; the first op's result is correct. Random regression of 1000 ops checks quotient*divisor+remainder == {hi,lo} and remainder < divisor when no error flag is set.

Source files
------------

// File: rtl/seq_divider32x16.sv
// Iterative restoring divider: {dividend_hi, dividend_lo} / divisor, one quotient bit per clock.
// Divide-by-zero and quotient overflow are resolved at accept and complete in a single cycle.
module seq_divider32x16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend_hi,
    input  logic [WIDTH-1:0] dividend_lo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow,
    output logic             zero_q
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dsr;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   r_sh;
    logic [WIDTH+1:0] diff;
    logic             step_ok;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;
    logic             accept;
    logic             last_step;

    // Difference is one bit wider than the partial remainder so its MSB is a clean borrow.
    always_comb begin
        r_sh      = {r[WIDTH-1:0], q[WIDTH-1]};
        diff      = {1'b0, r_sh} - {2'b00, dsr};
        step_ok   = ~diff[WIDTH+1];
        r_next    = step_ok ? diff[WIDTH:0] : r_sh;
        q_next    = {q[WIDTH-2:0], step_ok};
        accept    = start && (state != S_RUN);
        last_step = (count == CW'(WIDTH - 1));
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            r           <= '0;
            q           <= '0;
            dsr         <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            zero_q      <= 1'b0;
        end else if (state == S_RUN) begin
            if (abort) begin
                state <= S_IDLE;
            end else begin
                r     <= r_next;
                q     <= q_next;
                count <= count + 1'b1;
                if (last_step) begin
                    state     <= S_DONE;
                    quotient  <= q_next;
                    remainder <= r_next[WIDTH-1:0];
                    zero_q    <= (q_next == '0);
                end
            end
        end else if (accept) begin
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            zero_q      <= 1'b0;
            if (divisor == '0) begin
                state       <= S_DONE;
                div_by_zero <= 1'b1;
                quotient    <= '1;
                remainder   <= '0;
            end else if (dividend_hi >= divisor) begin
                state     <= S_DONE;
                overflow  <= 1'b1;
                quotient  <= '1;
                remainder <= '0;
            end else begin
                state <= S_RUN;
                r     <= {1'b0, dividend_hi};
                q     <= dividend_lo;
                dsr   <= divisor;
                count <= '0;
            end
        end else begin
            state <= S_IDLE;
        end
    end

endmodule

// File: tb/tb_seq_divider32x16.sv
// Scoreboard bench for seq_divider32x16: expectations are queued at start and checked at done.
module tb_seq_divider32x16;

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        logic        ovf;
        logic        zq;
    } res_t;

    typedef struct {
        logic [15:0] hi;
        logic [15:0] lo;
        logic [15:0] dv;
        res_t        res;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, start, abort;
    logic [15:0] dividend_hi, dividend_lo, divisor;
    logic [15:0] quotient, remainder;
    logic        busy, done, div_by_zero, overflow, zero_q;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    seq_divider32x16 #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .dividend_hi(dividend_hi), .dividend_lo(dividend_lo), .divisor(divisor),
        .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .overflow(overflow), .zero_q(zero_q)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [15:0] hi, input logic [15:0] lo, input logic [15:0] dv);
        res_t        m;
        logic [31:0] full;
        m    = '0;
        full = {hi, lo};
        if (dv == 16'd0) begin
            m.q = 16'hFFFF; m.dbz = 1'b1;
        end else if (hi >= dv) begin
            m.q = 16'hFFFF; m.ovf = 1'b1;
        end else begin
            m.q  = 16'(full / {16'd0, dv});
            m.r  = 16'(full % {16'd0, dv});
            m.zq = (m.q == 16'd0);
        end
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one accept edge and queues the expected outcome.
    task automatic do_start(input logic [15:0] hi, input logic [15:0] lo, input logic [15:0] dv);
        exp_t e;
        dividend_hi = hi; dividend_lo = lo; divisor = dv; start = 1'b1;
        e.hi = hi; e.lo = lo; e.dv = dv;
        e.res = model(hi, lo, dv);
        e.lat = (dv == 16'd0 || hi >= dv) ? 0 : 16;
        exp_q.push_back(e);
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(output int edges, output int busy_cnt);
        edges = 0; busy_cnt = 0;
        while (done !== 1'b1 && edges < 40) begin
            if (busy === 1'b1) busy_cnt++;
            step();
            edges++;
        end
    endtask

    function automatic res_t observed();
        return {quotient, remainder, div_by_zero, overflow, zero_q};
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 1'b1;
        dividend_hi = 16'h0; dividend_lo = 16'h0064; divisor = 16'h0007;
        step(); step();
        checks++;
        if ({observed(), busy, done} !== 37'd0) begin
            errors++; $display("FAIL reset_hold: got %h busy=%b done=%b, required all zero", observed(), busy, done);
        end
        start = 1'b0; reset = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_release: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        exp_t e; int edges, bc;
        do_start(16'h0000, 16'h0064, 16'h0007);
        wait_done(edges, bc);
        e = exp_q.pop_front();
        checks++;
        if (observed() !== e.res || edges != e.lat) begin
            errors++; $display("FAIL basic: got %h lat %0d, required %h lat %0d", observed(), edges, e.res, e.lat);
        end
        checks++;
        if (bc != 16 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_busy: busy cycles %0d busy_at_done=%b, required 16 and 0", bc, busy);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e; int edges, bc;
        do_start(16'hFFFE, 16'h0001, 16'hFFFF);
        wait_done(edges, bc);
        e = exp_q.pop_front();
        checks++;
        if (observed() !== e.res || edges != e.lat) begin
            errors++; $display("FAIL b2b_first: got %h lat %0d, required %h lat %0d", observed(), edges, e.res, e.lat);
        end
        do_start(16'h0000, 16'h0003, 16'h0010);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL b2b_accept: done=%b busy=%b, required 0 1", done, busy);
        end
        wait_done(edges, bc);
        e = exp_q.pop_front();
        checks++;
        if (observed() !== e.res || edges != e.lat) begin
            errors++; $display("FAIL b2b_second: got %h lat %0d, required %h lat %0d", observed(), edges, e.res, e.lat);
        end
    endtask

    task automatic test_errors();
        exp_t e; int edges, bc;
        do_start(16'h0005, 16'h1234, 16'h0000);
        wait_done(edges, bc);
        e = exp_q.pop_front();
        checks++;
        if (observed() !== e.res || edges != 0 || bc != 0) begin
            errors++; $display("FAIL div_zero: got %h lat %0d busy %0d, required %h lat 0 busy 0", observed(), edges, bc, e.res);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL done_pulse: done=%b, required 0", done);
        end
        do_start(16'h0010, 16'h0000, 16'h0010);
        wait_done(edges, bc);
        e = exp_q.pop_front();
        checks++;
        if (observed() !== e.res || edges != 0 || bc != 0) begin
            errors++; $display("FAIL overflow: got %h lat %0d busy %0d, required %h lat 0 busy 0", observed(), edges, bc, e.res);
        end
        step();
    endtask

    task automatic test_abort();
        exp_t e; int edges, bc, pulses;
        do_start(16'h0001, 16'h0000, 16'h0010);
        repeat (4) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        void'(exp_q.pop_back());
        checks++;
        if ({observed(), busy, done} !== {16'hFFFF, 16'h0, 3'b000, 2'b00}) begin
            errors++; $display("FAIL abort_state: got %h busy=%b done=%b, required ffff/0000 flags 0, busy 0 done 0", observed(), busy, done);
        end
        pulses = 0;
        repeat (20) begin step(); if (done !== 1'b0) pulses++; end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL abort_nodone: %0d done cycles, required 0", pulses);
        end
        abort = 1'b1;
        do_start(16'h0001, 16'h0000, 16'h0010);
        abort = 1'b0;
        wait_done(edges, bc);
        e = exp_q.pop_front();
        checks++;
        if (observed() !== e.res || e.res.q !== 16'h1000 || edges != e.lat) begin
            errors++; $display("FAIL abort_restart: got %h lat %0d, required %h lat %0d", observed(), edges, e.res, e.lat);
        end
        step();
    endtask

    task automatic test_reset_mid_run();
        int pulses;
        do_start(16'h0000, 16'h0064, 16'h0007);
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        void'(exp_q.pop_back());
        checks++;
        if ({observed(), busy, done} !== 37'd0) begin
            errors++; $display("FAIL reset_mid_run: got %h busy=%b done=%b, required all zero", observed(), busy, done);
        end
        pulses = 0;
        repeat (20) begin step(); if (done !== 1'b0) pulses++; end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL reset_nodone: %0d done cycles, required 0", pulses);
        end
    endtask

    task automatic test_start_ignored();
        exp_t e; int edges, bc;
        do_start(16'h0000, 16'd1000, 16'h0003);
        dividend_hi = 16'h0; dividend_lo = 16'd50; divisor = 16'd9; start = 1'b1;
        wait_done(edges, bc);
        start = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (observed() !== e.res || edges != 16) begin
            errors++; $display("FAIL start_ignored: got %h lat %0d, required %h lat 16", observed(), edges, e.res);
        end
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL no_queue: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_random();
        exp_t e; int edges, bc;
        logic [15:0] hi, lo, dv;
        for (int i = 0; i < 1000; i++) begin
            dv = 16'($urandom);
            if (i % 4 == 2) dv = 16'($urandom_range(15, 1));
            if (i % 50 == 7) dv = 16'd0;
            if (dv == 16'd0 || i % 8 == 1) hi = 16'($urandom);
            else hi = 16'($urandom_range(dv - 1, 0));
            lo = 16'($urandom);
            do_start(hi, lo, dv);
            wait_done(edges, bc);
            e = exp_q.pop_front();
            checks++;
            if (observed() !== e.res || edges != e.lat) begin
                errors++; $display("FAIL random_%0d: %h%h/%h got %h lat %0d, required %h lat %0d", i, hi, lo, dv, observed(), edges, e.res, e.lat);
            end
            if (!e.res.dbz && !e.res.ovf) begin
                checks++;
                if ((32'(quotient) * 32'(e.dv) + 32'(remainder)) !== {e.hi, e.lo} || remainder >= e.dv) begin
                    errors++; $display("FAIL invariant_%0d: q=%h r=%h dv=%h, required q*dv+r=%h%h and r<dv", i, quotient, remainder, e.dv, e.hi, e.lo);
                end
            end
            if (i % 2 == 1) step();
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        dividend_hi = '0; dividend_lo = '0; divisor = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_errors();
        test_abort();
        test_reset_mid_run();
        test_start_ignored();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
